// File: rtl/simple_regf_seq.sv
// rtl/simple_regf_seq.sv - single-issue execute sequencer driving a 16x8 register file
// Flow: accept in IDLE, then read (RD), compute (EX) and write back (WB); LDI and NOP go straight to WB.
module simple_regf_seq #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic [DW-1:0] instr_imm,
   output logic [AW-1:0] regf_raddrN,
   output logic [AW-1:0] regf_raddrM,
   input  logic [DW-1:0] regf_rdoutN,
   input  logic [DW-1:0] regf_rdoutM,
   output logic          regf_wren,
   output logic [AW-1:0] regf_waddr,
   output logic [DW-1:0] regf_wdin,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          ovf
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_LDI  = 3'd6;
   localparam logic [2:0] OP_ADDS = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

   state_t        state_q;
   logic [2:0]    op_q;
   logic [AW-1:0] rd_q, rs1_q, rs2_q;
   logic [DW-1:0] res_q;
   logic          res_ovf_q;
   logic          ready_q, wren_q, done_q;
   logic [DW-1:0] result_q;
   logic          ovf_q;

   logic [DW-1:0] alu_d;
   logic          alu_ovf_d;
   logic [DW-1:0] sum, dif;
   logic          add_ovf, sub_ovf;

   always_comb begin
      sum     = regf_rdoutN + regf_rdoutM;
      dif     = regf_rdoutN - regf_rdoutM;
      add_ovf = (regf_rdoutN[DW-1] == regf_rdoutM[DW-1]) && (sum[DW-1] != regf_rdoutN[DW-1]);
      sub_ovf = (regf_rdoutN[DW-1] != regf_rdoutM[DW-1]) && (dif[DW-1] != regf_rdoutN[DW-1]);
      alu_d     = '0;
      alu_ovf_d = 1'b0;
      case (op_q)
         OP_ADD: begin alu_d = sum; alu_ovf_d = add_ovf; end
         OP_SUB: begin alu_d = dif; alu_ovf_d = sub_ovf; end
         OP_AND: alu_d = regf_rdoutN & regf_rdoutM;
         OP_OR:  alu_d = regf_rdoutN | regf_rdoutM;
         OP_XOR: alu_d = regf_rdoutN ^ regf_rdoutM;
         OP_ADDS: begin
            // On overflow both operands share a sign, so clamp toward that sign.
            if (add_ovf)
               alu_d = regf_rdoutN[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            else
               alu_d = sum;
            alu_ovf_d = add_ovf;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NOP;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         res_q     <= '0;
         res_ovf_q <= 1'b0;
         ready_q   <= 1'b0;
         wren_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wren_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (instr_valid && ready_q) begin
                  ready_q   <= 1'b0;
                  op_q      <= instr_op;
                  rd_q      <= instr_rd;
                  rs1_q     <= instr_rs1;
                  rs2_q     <= instr_rs2;
                  res_q     <= instr_imm;
                  res_ovf_q <= 1'b0;
                  if (instr_op == OP_NOP || instr_op == OP_LDI) begin
                     state_q <= S_WB;
                     wren_q  <= (instr_op == OP_LDI);
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RD;
                  end
               end
            end
            S_RD: state_q <= S_EX;
            S_EX: begin
               res_q     <= alu_d;
               res_ovf_q <= alu_ovf_d;
               wren_q    <= 1'b1;
               done_q    <= 1'b1;
               state_q   <= S_WB;
            end
            S_WB: begin
               if (op_q != OP_NOP)
                  result_q <= res_q;
               ovf_q   <= res_ovf_q;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign regf_raddrN = rs1_q;
   assign regf_raddrM = rs2_q;
   assign regf_wren   = wren_q;
   assign regf_waddr  = rd_q;
   assign regf_wdin   = res_q;
   assign done        = done_q;
   assign result      = result_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_simple_regf_seq.sv
// tb/tb_simple_regf_seq.sv - scoreboard bench for simple_regf_seq with a registered-read regfile model
module tb_simple_regf_seq;

   logic       clk = 1'b0;
   logic       resetn;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [3:0] instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic [3:0] regf_raddrN, regf_raddrM, regf_waddr;
   logic [7:0] regf_rdoutN, regf_rdoutM, regf_wdin;
   logic       regf_wren, done, ovf;
   logic [7:0] result;

   typedef struct {
      logic       wren;
      logic [3:0] waddr;
      logic [7:0] wdin;
      logic [7:0] res;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   bit   chk_res = 0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   spacing_on = 0;
   int   last_done = -1;
   int   n_done_sp = 0;
   logic [7:0] mem [16];

   simple_regf_seq #(.DW(8), .AW(4)) dut (
      .clk(clk), .resetn(resetn),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .regf_raddrN(regf_raddrN), .regf_raddrM(regf_raddrM),
      .regf_rdoutN(regf_rdoutN), .regf_rdoutM(regf_rdoutM),
      .regf_wren(regf_wren), .regf_waddr(regf_waddr), .regf_wdin(regf_wdin),
      .done(done), .result(result), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

   always @(posedge clk) begin
      cyc++;
      if (regf_wren) mem[regf_waddr] <= regf_wdin;
      regf_rdoutN <= mem[regf_raddrN];
      regf_rdoutM <= mem[regf_raddrM];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_res) begin
         chk("result", result, pend.res);
         chk("ovf", ovf, pend.ovf);
         chk_res = 0;
      end
      if (resetn) begin
         chk("wren_only_wb", regf_wren & ~done, 0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               pend = sb.pop_front();
               chk("wren", regf_wren, pend.wren);
               if (pend.wren) begin
                  chk("waddr", regf_waddr, pend.waddr);
                  chk("wdin", regf_wdin, pend.wdin);
               end
               chk("ready_in_wb", instr_ready, 0);
               chk_res = 1;
               if (spacing_on) begin
                  if (last_done >= 0) chk("done_spacing", cyc - last_done, 4);
                  last_done = cyc;
                  n_done_sp++;
               end
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [7:0] imm, input logic ewren,
                        input logic [7:0] ewdin, input logic [7:0] eres, input logic eovf,
                        input bit push, input bit hold);
      int n;
      if (push) sb.push_back('{ewren, rd, ewdin, eres, eovf});
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", int'(n < 100), 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         instr_valid = 1'b0;
         instr_op = 3'($urandom); instr_rd = 4'($urandom);
         instr_rs1 = 4'($urandom); instr_rs2 = 4'($urandom); instr_imm = 8'($urandom);
      end
      if (op != 3'd0 && op != 3'd6) begin
         @(negedge clk);
         chk("raddrN_rd", regf_raddrN, rs1);
         chk("raddrM_rd", regf_raddrM, rs2);
         chk("wren_rd", regf_wren, 0);
         chk("ready_rd", instr_ready, 0);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || chk_res) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", int'(n < 100), 1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0; instr_valid = 1'b0;
      instr_op = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0; instr_imm = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", instr_ready, 0);
      chk("rst_wren", regf_wren, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_raddrN", regf_raddrN, 0);
      chk("rst_waddr", regf_waddr, 0);
      chk("rst_wdin", regf_wdin, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", instr_ready, 1);

      //     op   rd  rs1 rs2 imm    wren wdin   result ovf push hold
      issue(3'd6, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0);
      issue(3'd6, 1, 0, 0, 8'h64, 1, 8'h64, 8'h64, 0, 1, 0);
      issue(3'd6, 2, 0, 0, 8'h32, 1, 8'h32, 8'h32, 0, 1, 0);
      issue(3'd1, 3, 1, 2, 8'h00, 1, 8'h96, 8'h96, 1, 1, 0);
      issue(3'd1, 6, 3, 0, 8'h00, 1, 8'h96, 8'h96, 0, 1, 0);
      issue(3'd7, 4, 1, 2, 8'h00, 1, 8'h7F, 8'h7F, 1, 1, 0);
      issue(3'd2, 5, 2, 1, 8'h00, 1, 8'hCE, 8'hCE, 0, 1, 0);
      issue(3'd5, 7, 1, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0);
      issue(3'd3, 8, 1, 2, 8'h00, 1, 8'h20, 8'h20, 0, 1, 0);
      issue(3'd4, 9, 1, 2, 8'h00, 1, 8'h76, 8'h76, 0, 1, 0);
      issue(3'd6, 10, 0, 0, 8'h9C, 1, 8'h9C, 8'h9C, 0, 1, 0);
      issue(3'd7, 11, 10, 10, 8'h00, 1, 8'h80, 8'h80, 1, 1, 0);
      issue(3'd0, 12, 0, 0, 8'h00, 0, 8'h00, 8'h80, 0, 1, 0);
      drain();

      spacing_on = 1; last_done = -1; n_done_sp = 0;
      issue(3'd1, 12, 1, 0, 8'h00, 1, 8'h64, 8'h64, 0, 1, 1);
      issue(3'd1, 13, 2, 0, 8'h00, 1, 8'h32, 8'h32, 0, 1, 1);
      issue(3'd1, 14, 1, 2, 8'h00, 1, 8'h96, 8'h96, 1, 1, 1);
      instr_valid = 1'b0;
      drain();
      spacing_on = 0;
      chk("done_count_pipelined", n_done_sp, 3);

      issue(3'd1, 1, 1, 1, 8'h00, 1, 8'hC8, 8'hC8, 1, 1, 0);
      issue(3'd2, 2, 1, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 0);
      drain();

      issue(3'd1, 3, 1, 2, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_ex_wren", regf_wren, 0);
      chk("rst_ex_done", done, 0);
      chk("rst_ex_result", result, 0);
      chk("rst_ex_ovf", ovf, 0);
      chk("rst_ex_ready", instr_ready, 0);
      chk("rst_ex_wdin", regf_wdin, 0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_wren", regf_wren, 0);
         chk("rst_hold_done", done, 0);
      end
      resetn = 1'b1;
      @(negedge clk);
      chk("ready_after_midrst", instr_ready, 1);
      issue(3'd1, 15, 3, 0, 8'h00, 1, 8'h96, 8'h96, 0, 1, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
